// File: rtl/qtpa_pkg.sv
// Shared QTP-A/QTP-S types: ALU width, branch condition codes,
// branch-resolve FSM states and the architectural flag bundle.
package qtpa_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [3:0] {
        EQ, NE, LTU, GEU, VS, VC, LEU, GTU, AL, NV
    } cond_t;

    typedef enum logic {
        BR_IDLE,
        BR_PEND
    } br_state_t;

    typedef struct packed {
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/qtps_cond_eval.sv
// Combinational condition-code evaluator, shared by branch
// resolution and predicated execution.
module qtps_cond_eval
    import qtpa_pkg::*;
(
    input  flags_t flags,
    input  cond_t  cond,
    output logic   taken
);

    always_comb begin
        taken = 1'b0;
        unique case (1'b1)
            (cond == EQ):  taken = flags.z;
            (cond == NE):  taken = ~flags.z;
            (cond == LTU): taken = flags.c;
            (cond == GEU): taken = ~flags.c;
            (cond == VS):  taken = flags.v;
            (cond == VC):  taken = ~flags.v;
            (cond == LEU): taken = flags.c | flags.z;
            (cond == GTU): taken = ~flags.c & ~flags.z;
            (cond == AL):  taken = 1'b1;
            default:       taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/qtps_branch_resolve.sv
// Flag register, conditional branch evaluation and registered
// fetch redirect with taken/not-taken performance counters.
module qtps_branch_resolve
    import qtpa_pkg::*;
#(
    parameter int DATA_WIDTH = qtpa_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  ex_flag_we,
    input  logic                  ex_zero,
    input  logic                  ex_carry,
    input  logic                  ex_ovf,
    input  logic                  br_valid,
    output logic                  br_ready,
    input  cond_t                 br_cond,
    input  logic [ADDR_WIDTH-1:0] br_target,
    input  logic                  flush,
    output logic                  redir_valid,
    input  logic                  redir_ready,
    output logic [ADDR_WIDTH-1:0] redir_pc,
    output logic [2:0]            flags_q,
    output logic [CNT_WIDTH-1:0]  cnt_taken,
    output logic [CNT_WIDTH-1:0]  cnt_not_taken
);

    localparam int CW = (CNT_WIDTH < DATA_WIDTH) ? CNT_WIDTH : DATA_WIDTH;

    br_state_t       state_q;
    flags_t          flags_r;
    flags_t          ex_flags;
    flags_t          eval_flags;
    logic            flag_wr;
    logic            br_taken;
    logic            accept;
    logic [CW-1:0]   taken_q;
    logic [CW-1:0]   nt_q;

    assign flag_wr    = ex_valid & ex_flag_we;
    assign ex_flags   = '{z: ex_zero, c: ex_carry, v: ex_ovf};
    // Same-cycle EX flags bypass the register so a branch never stalls
    assign eval_flags = flag_wr ? ex_flags : flags_r;

    qtps_cond_eval u_cond_eval (
        .flags (eval_flags),
        .cond  (br_cond),
        .taken (br_taken)
    );

    assign br_ready      = (state_q == BR_IDLE);
    assign accept        = br_valid & br_ready & ~flush;
    assign flags_q       = flags_r;
    assign cnt_taken     = CNT_WIDTH'(taken_q);
    assign cnt_not_taken = CNT_WIDTH'(nt_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BR_IDLE;
            flags_r     <= '0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            taken_q     <= '0;
            nt_q        <= '0;
        end else begin
            if (flag_wr)
                flags_r <= ex_flags;
            if (flush) begin
                state_q     <= BR_IDLE;
                redir_valid <= 1'b0;
            end else begin
                unique case (state_q)
                    BR_IDLE: begin
                        if (accept && br_taken) begin
                            redir_pc    <= br_target;
                            redir_valid <= 1'b1;
                            state_q     <= BR_PEND;
                        end else if (accept && (nt_q != '1)) begin
                            nt_q <= nt_q + CW'(1);
                        end
                    end
                    BR_PEND: begin
                        if (redir_ready) begin
                            redir_valid <= 1'b0;
                            state_q     <= BR_IDLE;
                            if (taken_q != '1)
                                taken_q <= taken_q + CW'(1);
                        end
                    end
                    default: state_q <= BR_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qtps_branch_resolve.sv
// Directed vector table, saturation sequences and randomized
// run against a behavioural model of the branch-resolve unit.
module tb_qtps_branch_resolve;
    import qtpa_pkg::*;

    localparam int AW   = 16;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid, ex_flag_we, ex_zero, ex_carry, ex_ovf;
    logic          br_valid, br_ready;
    cond_t         br_cond;
    logic [AW-1:0] br_target;
    logic          flush;
    logic          redir_valid, redir_ready;
    logic [AW-1:0] redir_pc;
    logic [2:0]    flags_q;
    logic [CW-1:0] cnt_taken, cnt_not_taken;

    always #5 clk = ~clk;

    qtps_branch_resolve #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_flag_we    (ex_flag_we),
        .ex_zero       (ex_zero),
        .ex_carry      (ex_carry),
        .ex_ovf        (ex_ovf),
        .br_valid      (br_valid),
        .br_ready      (br_ready),
        .br_cond       (br_cond),
        .br_target     (br_target),
        .flush         (flush),
        .redir_valid   (redir_valid),
        .redir_ready   (redir_ready),
        .redir_pc      (redir_pc),
        .flags_q       (flags_q),
        .cnt_taken     (cnt_taken),
        .cnt_not_taken (cnt_not_taken)
    );

    typedef struct {
        logic       rst, exv, we;
        logic [2:0] zcv;
        logic       bv;
        logic [3:0] cond;
        logic [15:0] tgt;
        logic       fl, rr;
        logic       e_rv;
        logic [15:0] e_pc;
        logic [2:0] e_flg;
        int         e_t, e_nt;
        logic       e_rdy;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [2:0]  m_flags;
    bit          m_pend;
    logic [15:0] m_pc;
    int          m_t, m_nt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, req, $time);
        end
    endtask

    function automatic vec_t mk(
        logic r, logic exv, logic we, logic [2:0] zcv,
        logic bv, logic [3:0] cond, logic [15:0] tgt, logic fl, logic rr,
        logic rv, logic [15:0] pc, logic [2:0] flg, int t, int nt,
        logic rdy);
        vec_t v;
        v.rst = r; v.exv = exv; v.we = we; v.zcv = zcv;
        v.bv = bv; v.cond = cond; v.tgt = tgt; v.fl = fl; v.rr = rr;
        v.e_rv = rv; v.e_pc = pc; v.e_flg = flg;
        v.e_t = t; v.e_nt = nt; v.e_rdy = rdy;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst         = v.rst;
        ex_valid    = v.exv;
        ex_flag_we  = v.we;
        {ex_zero, ex_carry, ex_ovf} = v.zcv;
        br_valid    = v.bv;
        br_cond     = cond_t'(v.cond);
        br_target   = v.tgt;
        flush       = v.fl;
        redir_ready = v.rr;
    endtask

    task automatic idle_inputs();
        rst = 0; ex_valid = 0; ex_flag_we = 0;
        ex_zero = 0; ex_carry = 0; ex_ovf = 0;
        br_valid = 0; br_cond = NV; br_target = '0;
        flush = 0; redir_ready = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit cond_true(logic [2:0] f, logic [3:0] c);
        bit z = f[2], cy = f[1], v = f[0];
        case (c)
            4'd0: return z;
            4'd1: return !z;
            4'd2: return cy;
            4'd3: return !cy;
            4'd4: return v;
            4'd5: return !v;
            4'd6: return cy || z;
            4'd7: return !cy && !z;
            4'd8: return 1;
            default: return 0;
        endcase
    endfunction

    // Advance the model by one clock using the currently driven inputs
    task automatic model_step();
        logic [2:0] f;
        if (rst) begin
            m_flags = 0; m_pend = 0; m_pc = 0; m_t = 0; m_nt = 0;
            return;
        end
        f = (ex_valid && ex_flag_we) ? {ex_zero, ex_carry, ex_ovf} : m_flags;
        m_flags = f;
        if (flush) begin
            m_pend = 0;
        end else if (!m_pend) begin
            if (br_valid) begin
                if (cond_true(f, 4'(br_cond))) begin
                    m_pend = 1;
                    m_pc = br_target;
                end else begin
                    m_nt = (m_nt < CMAX) ? m_nt + 1 : CMAX;
                end
            end
        end else if (redir_ready) begin
            m_pend = 0;
            m_t = (m_t < CMAX) ? m_t + 1 : CMAX;
        end
    endtask

    vec_t tbl[22];

    initial begin
        idle_inputs();
        //            rst ex we zcv    bv cond  tgt      fl rr | rv pc       flg    t  nt rdy
        tbl[0]  = mk(1, 0, 0, 3'b000, 0, 4'd9, 16'h0000, 0, 0, 0, 16'h0000, 3'b000, 0, 0, 1);
        tbl[1]  = mk(0, 0, 0, 3'b000, 0, 4'd9, 16'h0000, 0, 0, 0, 16'h0000, 3'b000, 0, 0, 1);
        tbl[2]  = mk(0, 1, 1, 3'b100, 0, 4'd9, 16'h0000, 0, 0, 0, 16'h0000, 3'b100, 0, 0, 1);
        tbl[3]  = mk(0, 0, 0, 3'b000, 1, 4'd0, 16'h0040, 0, 0, 1, 16'h0040, 3'b100, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 3'b000, 0, 4'd9, 16'h0000, 0, 1, 0, 16'h0040, 3'b100, 1, 0, 1);
        tbl[5]  = mk(0, 1, 1, 3'b000, 1, 4'd1, 16'h0080, 0, 0, 1, 16'h0080, 3'b000, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0, 3'b000, 0, 4'd9, 16'h0000, 0, 1, 0, 16'h0080, 3'b000, 2, 0, 1);
        tbl[7]  = mk(0, 0, 0, 3'b000, 1, 4'd7, 16'h0100, 0, 0, 1, 16'h0100, 3'b000, 2, 0, 0);
        tbl[8]  = mk(0, 0, 0, 3'b000, 1, 4'd8, 16'h0200, 0, 0, 1, 16'h0100, 3'b000, 2, 0, 0);
        tbl[9]  = mk(0, 0, 0, 3'b000, 1, 4'd8, 16'h0200, 0, 0, 1, 16'h0100, 3'b000, 2, 0, 0);
        tbl[10] = mk(0, 0, 0, 3'b000, 1, 4'd8, 16'h0200, 0, 1, 0, 16'h0100, 3'b000, 3, 0, 1);
        tbl[11] = mk(0, 0, 0, 3'b000, 0, 4'd9, 16'h0000, 0, 0, 0, 16'h0100, 3'b000, 3, 0, 1);
        tbl[12] = mk(0, 0, 0, 3'b000, 1, 4'd8, 16'h0300, 0, 0, 1, 16'h0300, 3'b000, 3, 0, 0);
        tbl[13] = mk(0, 0, 0, 3'b000, 0, 4'd9, 16'h0000, 1, 0, 0, 16'h0300, 3'b000, 3, 0, 1);
        tbl[14] = mk(0, 0, 0, 3'b000, 1, 4'd8, 16'h0400, 0, 0, 1, 16'h0400, 3'b000, 3, 0, 0);
        tbl[15] = mk(0, 0, 0, 3'b000, 0, 4'd9, 16'h0000, 1, 1, 0, 16'h0400, 3'b000, 3, 0, 1);
        tbl[16] = mk(0, 0, 0, 3'b000, 1, 4'd8, 16'h0500, 1, 0, 0, 16'h0400, 3'b000, 3, 0, 1);
        tbl[17] = mk(0, 0, 0, 3'b000, 1, 4'd4, 16'h0600, 0, 0, 0, 16'h0400, 3'b000, 3, 1, 1);
        tbl[18] = mk(0, 0, 0, 3'b000, 1, 4'd12, 16'h0650, 0, 0, 0, 16'h0400, 3'b000, 3, 2, 1);
        tbl[19] = mk(0, 1, 0, 3'b110, 1, 4'd6, 16'h0700, 0, 0, 0, 16'h0400, 3'b000, 3, 3, 1);
        tbl[20] = mk(0, 0, 0, 3'b000, 1, 4'd8, 16'h0800, 0, 0, 1, 16'h0800, 3'b000, 3, 3, 0);
        tbl[21] = mk(1, 0, 0, 3'b000, 0, 4'd9, 16'h0000, 0, 0, 0, 16'h0000, 3'b000, 0, 0, 1);

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i]);
            step();
            chk($sformatf("tbl%0d_redir_valid", i), 32'(redir_valid), 32'(tbl[i].e_rv));
            chk($sformatf("tbl%0d_redir_pc", i), 32'(redir_pc), 32'(tbl[i].e_pc));
            chk($sformatf("tbl%0d_flags", i), 32'(flags_q), 32'(tbl[i].e_flg));
            chk($sformatf("tbl%0d_cnt_taken", i), 32'(cnt_taken), tbl[i].e_t);
            chk($sformatf("tbl%0d_cnt_not_taken", i), 32'(cnt_not_taken), tbl[i].e_nt);
            chk($sformatf("tbl%0d_br_ready", i), 32'(br_ready), 32'(tbl[i].e_rdy));
        end

        // Not-taken counter saturation
        idle_inputs();
        for (int i = 0; i < CMAX; i++) begin
            br_valid = 1; br_cond = NV;
            step();
        end
        chk("nt_reach_max", 32'(cnt_not_taken), CMAX);
        step();
        chk("nt_saturated", 32'(cnt_not_taken), CMAX);

        // Taken counter saturation
        for (int i = 0; i < CMAX + 1; i++) begin
            br_valid = 1; br_cond = AL; br_target = 16'(i); redir_ready = 0;
            step();
            br_valid = 0; redir_ready = 1;
            step();
            if (i == CMAX - 1)
                chk("t_reach_max", 32'(cnt_taken), CMAX);
        end
        chk("t_saturated", 32'(cnt_taken), CMAX);
        chk("t_sat_idle", 32'(redir_valid), 0);

        // Randomized run against the model
        idle_inputs();
        rst = 1;
        model_step();
        step();
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 199) == 0);
            ex_valid    = $urandom_range(0, 1);
            ex_flag_we  = $urandom_range(0, 1);
            ex_zero     = $urandom_range(0, 1);
            ex_carry    = $urandom_range(0, 1);
            ex_ovf      = $urandom_range(0, 1);
            br_valid    = ($urandom_range(0, 2) != 0);
            br_cond     = cond_t'(4'($urandom_range(0, 15)));
            br_target   = 16'($urandom);
            flush       = ($urandom_range(0, 9) == 0);
            redir_ready = ($urandom_range(0, 2) != 0);
            model_step();
            step();
            chk("rnd_redir_valid", 32'(redir_valid), 32'(m_pend));
            chk("rnd_redir_pc", 32'(redir_pc), 32'(m_pc));
            chk("rnd_flags", 32'(flags_q), 32'(m_flags));
            chk("rnd_cnt_taken", 32'(cnt_taken), m_t);
            chk("rnd_cnt_not_taken", 32'(cnt_not_taken), m_nt);
            chk("rnd_br_ready", 32'(br_ready), 32'(!m_pend));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
